// File: rtl/h_gate_sequencer.sv
// Hadamard sequencer: sweeps every amplitude pair of a 2^NQ state-vector RAM for one target qubit.
// Optional macro HSEQ_ALL_QUBITS_EN: target==NQ runs a Walsh-Hadamard sweep over all qubits.
module h_gate_sequencer #(
    parameter int unsigned NQ = 3,
    parameter int unsigned AW = NQ,
    parameter int unsigned TW = $clog2(NQ + 1)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_start,
    input  logic [TW-1:0] i_target,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_err,
    output logic          o_rd_en,
    output logic [AW-1:0] o_rd_addr,
    input  logic [31:0]   i_rd_data,
    output logic          o_wr_en,
    output logic [AW-1:0] o_wr_addr,
    output logic [31:0]   o_wr_data
);

    // Pair counter keeps at least one bit so NQ==1 still elaborates.
    localparam int unsigned KW = (NQ > 1) ? NQ - 1 : 1;
    localparam logic [KW-1:0] KLast = KW'((32'd1 << (NQ - 1)) - 32'd1);
    localparam logic [TW-1:0] TLast = TW'(NQ - 1);

    typedef enum logic [2:0] {
        StIdle,
        StRdA,
        StRdB,
        StCapB,
        StWr0,
        StWr1,
        StDone
    } state_e;

    state_e        r_state, w_state_d;
    logic [KW-1:0] r_k, w_k_d;
    logic [TW-1:0] r_tgt, w_tgt_d;
    logic          r_all, w_all_d;
    logic [31:0]   r_a, w_a_d;
    logic [31:0]   r_b, w_b_d;
    logic          r_err, w_err_d;

    logic          w_legal;
    logic          w_is_all;
    logic [AW-1:0] w_bit, w_lo_mask, w_kext, w_idx0, w_idx1;
    logic [16:0]   w_sum_re, w_sum_im, w_dif_re, w_dif_im;
    logic [31:0]   w_out0, w_out1;

`ifdef HSEQ_ALL_QUBITS_EN
    assign w_legal  = (32'(i_target) <= NQ);
    assign w_is_all = (32'(i_target) == NQ);
`else
    assign w_legal  = (32'(i_target) < NQ);
    assign w_is_all = 1'b0;
`endif

    // idx0 is k with a zero spliced in at bit position r_tgt.
    assign w_bit     = AW'(1) << r_tgt;
    assign w_lo_mask = w_bit - AW'(1);
    assign w_kext    = AW'(r_k);
    assign w_idx0    = ((w_kext & ~w_lo_mask) << 1) | (w_kext & w_lo_mask);
    assign w_idx1    = w_idx0 | w_bit;

    function automatic logic [15:0] h_scale(input logic signed [16:0] s);
        logic signed [32:0] p;
        p = 33'(s) * 33'sd23170;
        return 16'(p >>> 15);
    endfunction

    assign w_sum_re = {r_a[31], r_a[31:16]} + {r_b[31], r_b[31:16]};
    assign w_sum_im = {r_a[15], r_a[15:0]} + {r_b[15], r_b[15:0]};
    assign w_dif_re = {r_a[31], r_a[31:16]} - {r_b[31], r_b[31:16]};
    assign w_dif_im = {r_a[15], r_a[15:0]} - {r_b[15], r_b[15:0]};
    assign w_out0   = {h_scale(w_sum_re), h_scale(w_sum_im)};
    assign w_out1   = {h_scale(w_dif_re), h_scale(w_dif_im)};

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= StIdle;
            r_k     <= '0;
            r_tgt   <= '0;
            r_all   <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_k     <= w_k_d;
            r_tgt   <= w_tgt_d;
            r_all   <= w_all_d;
            r_a     <= w_a_d;
            r_b     <= w_b_d;
            r_err   <= w_err_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_k_d     = r_k;
        w_tgt_d   = r_tgt;
        w_all_d   = r_all;
        w_a_d     = r_a;
        w_b_d     = r_b;
        w_err_d   = 1'b0;
        o_busy    = (r_state != StIdle);
        o_done    = 1'b0;
        o_rd_en   = 1'b0;
        o_rd_addr = '0;
        o_wr_en   = 1'b0;
        o_wr_addr = '0;
        o_wr_data = '0;
        unique case (r_state)
            StIdle: begin
                if (i_start) begin
                    if (w_legal) begin
                        w_state_d = StRdA;
                        w_k_d     = '0;
                        w_all_d   = w_is_all;
                        w_tgt_d   = w_is_all ? '0 : i_target;
                    end else begin
                        w_err_d = 1'b1;
                    end
                end
            end
            StRdA: begin
                o_rd_en   = 1'b1;
                o_rd_addr = w_idx0;
                w_state_d = StRdB;
            end
            StRdB: begin
                o_rd_en   = 1'b1;
                o_rd_addr = w_idx1;
                w_a_d     = i_rd_data;
                w_state_d = StCapB;
            end
            StCapB: begin
                w_b_d     = i_rd_data;
                w_state_d = StWr0;
            end
            StWr0: begin
                o_wr_en   = 1'b1;
                o_wr_addr = w_idx0;
                o_wr_data = w_out0;
                w_state_d = StWr1;
            end
            StWr1: begin
                o_wr_en   = 1'b1;
                o_wr_addr = w_idx1;
                o_wr_data = w_out1;
                if (r_k == KLast) begin
                    // All-qubit mode chains straight into the next qubit's sweep.
                    if (r_all && (r_tgt != TLast)) begin
                        w_tgt_d   = r_tgt + TW'(1);
                        w_k_d     = '0;
                        w_state_d = StRdA;
                    end else begin
                        w_state_d = StDone;
                    end
                end else begin
                    w_k_d     = r_k + KW'(1);
                    w_state_d = StRdA;
                end
            end
            StDone: begin
                o_done    = 1'b1;
                w_state_d = StIdle;
            end
            default: w_state_d = StIdle;
        endcase
    end

    assign o_err = r_err;

endmodule

// File: tb/tb_h_gate_sequencer.sv
// Scoreboard bench for h_gate_sequencer (NQ=3) with a behavioural 1-cycle-latency RAM.
module tb_h_gate_sequencer;

    localparam int NQ = 3;
    localparam int AW = 3;
    localparam int TW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [TW-1:0] target = '0;
    logic          busy, done, err, rd_en, wr_en;
    logic [AW-1:0] rd_addr, wr_addr;
    logic [31:0]   rd_data = '0;
    logic [31:0]   wr_data;

    logic [31:0]   mem [8];
    logic          ld_en = 1'b0;
    logic [2:0]    ld_addr = '0;
    logic [31:0]   ld_data = '0;

    typedef struct packed {
        logic [2:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  n_checks = 0;
    int  n_fail = 0;
    int  done_cnt = 0;
    int  done_base = 0;
    int  err_cnt = 0;
    int  strobe_cnt = 0;
    int  rd_cnt = 0;
    int  wr_par = 0;

    h_gate_sequencer #(.NQ(NQ)) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_start   (start),
        .i_target  (target),
        .o_busy    (busy),
        .o_done    (done),
        .o_err     (err),
        .o_rd_en   (rd_en),
        .o_rd_addr (rd_addr),
        .i_rd_data (rd_data),
        .o_wr_en   (wr_en),
        .o_wr_addr (wr_addr),
        .o_wr_data (wr_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ld_en) mem[ld_addr] <= ld_data;
        else if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data <= mem[rd_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic monitor();
        wr_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                rd_cnt = 0;
                wr_par = 0;
            end else begin
                if (done) done_cnt++;
                if (err) err_cnt++;
                if (rd_en || wr_en) begin
                    strobe_cnt++;
                    check("strobe_overlap", 32'(rd_en & wr_en), 32'd0);
                end
                if (rd_en) rd_cnt++;
                if (wr_en) begin
                    check("reads_before_write", rd_cnt, 32'd2);
                    if (exp_q.size() == 0) begin
                        check("unexpected_write_queue", 32'(exp_q.size()), 32'd1);
                    end else begin
                        e = exp_q.pop_front();
                        check("wr_addr", 32'(wr_addr), 32'(e.addr));
                        check("wr_data", wr_data, e.data);
                    end
                    wr_par ^= 1;
                    if (wr_par == 0) rd_cnt = 0;
                end
            end
        end
    endtask

    // Entered and left at a negedge; loads all 8 words, zero except the two given.
    task automatic load(input logic [2:0] a0, input logic [31:0] v0,
                        input logic [2:0] a1, input logic [31:0] v1);
        for (int i = 0; i < 8; i++) begin
            ld_en   = 1'b1;
            ld_addr = 3'(i);
            ld_data = (3'(i) == a0) ? v0 : ((3'(i) == a1) ? v1 : 32'h0);
            @(negedge clk);
        end
        ld_en = 1'b0;
    endtask

    // Eight expected writes; addrs holds one octal digit per write, first write in the top digit.
    task automatic push_run(input logic [23:0] addrs, input logic [31:0] d0,
                            input logic [31:0] d1, input int nz);
        wr_t e;
        for (int i = 0; i < 8; i++) begin
            e.addr = addrs[3*(7-i) +: 3];
            e.data = (i == 0) ? d0 : ((i < nz) ? d1 : 32'h0);
            exp_q.push_back(e);
        end
    endtask

    // Raises start at a negedge and counts negedges until done; poke re-pulses start mid-run.
    task automatic run_op(input logic [TW-1:0] tgt, input int exp_lat, input string name,
                          input bit poke);
        int n;
        n = 0;
        start  = 1'b1;
        target = tgt;
        while (n < 400) begin
            @(negedge clk);
            n++;
            if (busy) begin
                start  = 1'b0;
                target = tgt ^ 2'b11;
            end
            if (poke && n == 8) begin
                start  = 1'b1;
                target = 2'd0;
            end
            if (done) break;
        end
        start = 1'b0;
        check({name, "_latency"}, n, exp_lat);
        check({name, "_busy_at_done"}, 32'(busy), 32'd1);
    endtask

    task automatic finish_op(input string name, input int exp_done);
        @(negedge clk);
        check({name, "_busy_after"}, 32'(busy), 32'd0);
        check({name, "_done_count"}, done_cnt - done_base, exp_done);
        check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
        done_base = done_cnt;
    endtask

    initial begin
        logic [31:0] saved;
        fork
            monitor();
        join_none

        repeat (2) @(negedge clk);
        check("reset_ctrl", {27'd0, busy, done, err, rd_en, wr_en}, 32'd0);
        check("reset_addrs", {26'd0, rd_addr, wr_addr}, 32'd0);
        check("reset_wr_data", wr_data, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Target qubit 0 on a basis state.
        load(3'd0, 32'h7FFF_0000, 3'd0, 32'h7FFF_0000);
        push_run(24'o01234567, 32'h5A81_0000, 32'h5A81_0000, 2);
        run_op(2'd0, 21, "q0", 1'b0);
        finish_op("q0", 1);

        // Qubit 1 applied twice back-to-back; second start held through DONE.
        load(3'd0, 32'h7FFF_0000, 3'd0, 32'h7FFF_0000);
        push_run(24'o02134657, 32'h5A81_0000, 32'h5A81_0000, 2);
        run_op(2'd1, 21, "h1a", 1'b0);
        push_run(24'o02134657, 32'h7FFD_0000, 32'h0, 2);
        run_op(2'd1, 22, "h1b", 1'b0);
        finish_op("h1", 2);
        check("mem0_after_hh", mem[0], 32'h7FFD_0000);

        // Negative/imaginary operands on qubit 2, with a stray start while busy.
        load(3'd0, 32'h8000_7FFF, 3'd4, 32'h7FFF_8000);
        push_run(24'o04152637, 32'hFFFF_FFFF, 32'h4AFC_B503, 2);
        run_op(2'd2, 21, "neg", 1'b1);
        finish_op("neg", 1);

`ifdef HSEQ_ALL_QUBITS_EN
        load(3'd0, 32'h7FFF_0000, 3'd0, 32'h7FFF_0000);
        push_run(24'o01234567, 32'h5A81_0000, 32'h5A81_0000, 2);
        push_run(24'o02134657, 32'h3FFE_0000, 32'h3FFE_0000, 4);
        push_run(24'o04152637, 32'h2D3F_0000, 32'h2D3F_0000, 8);
        run_op(2'd3, 61, "all", 1'b0);
        finish_op("all", 1);
        check("all_mem7", mem[7], 32'h2D3F_0000);
`else
        begin
            int err_base;
            int strobe_base;
            err_base    = err_cnt;
            strobe_base = strobe_cnt;
            start  = 1'b1;
            target = 2'd3;
            @(negedge clk);
            start = 1'b0;
            check("err_pulse", 32'(err), 32'd1);
            check("err_busy", 32'(busy), 32'd0);
            @(negedge clk);
            check("err_single", 32'(err), 32'd0);
            repeat (3) @(negedge clk);
            check("err_count", err_cnt - err_base, 32'd1);
            check("err_no_strobes", strobe_cnt - strobe_base, 32'd0);
        end
`endif

        // Reset asserted during WR_0 of the first pair.
        saved  = mem[0];
        start  = 1'b1;
        target = 2'd0;
        @(negedge clk);
        start = 1'b0;
        check("rst_run_started", 32'(busy), 32'd1);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 check("rst_in_wr0", 32'(wr_en), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_ctrl", {27'd0, busy, done, err, rd_en, wr_en}, 32'd0);
        check("rst_mid_data", {wr_data[31:6], rd_addr, wr_addr}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_after_ctrl", {27'd0, busy, done, err, rd_en, wr_en}, 32'd0);
        check("rst_mem_untouched", mem[0], saved);
        check("final_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
